// File: rtl/bus_cycle_if.sv
// bus_cycle_if: memory/iopage bus between the bus cycle sequencer and the
// memory or device that answers it.
//
//   mem_req    request, held until ack or timeout
//   mem_we     write strobe, valid with mem_req
//   mem_be     byte enables [1]=high byte, [0]=low byte, valid with mem_req
//   mem_addr   22-bit word address (bit 0 always 0)
//   mem_wdata  write data, byte writes replicated on both lanes
//   mem_ack    one-cycle acknowledge from the responder
//   mem_rdata  read data, valid with mem_ack
//
// master: the sequencer side. slave: the memory/device side.
interface bus_cycle_if;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_be;
   logic [21:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/bus_cycle.sv
// bus_cycle: runs one request/acknowledge cycle per CPU data access, using the
// physical address and abort/trap status produced by the MMU.
// Odd word addresses and MMU aborts complete at once without touching the bus.
// A request left unanswered for TIMEOUT cycles completes with a non-existent
// memory (NXM) error.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   req_rd, req_wr  CPU read/write request, sampled in IDLE only (write wins)
//   req_byte        byte (1) or word (0) access
//   cpu_pa          22-bit physical address from the MMU
//   cpu_wdata       write data, byte writes use [7:0]
//   mmu_abort       MMU abort for this request
//   mmu_trap        MMU trap (non-aborting) for this request
//   bus             memory bus, master side (see bus_cycle_if)
//   busy            sequencer not idle
//   done            one-cycle completion pulse
//   rdata           read result, held until the next completed read
//   err_odd         odd word address, valid with done
//   err_abort       MMU abort, valid with done
//   err_nxm         bus timeout, valid with done
//   trap_req        MMU trap to take after the instruction, valid with done
module bus_cycle #(
   parameter int unsigned TIMEOUT = 16,  // 2..255
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_rd,
   input  logic               req_wr,
   input  logic               req_byte,
   input  logic [21:0]        cpu_pa,
   input  logic [15:0]        cpu_wdata,
   input  logic               mmu_abort,
   input  logic               mmu_trap,
   bus_cycle_if.master        bus,
   output logic               busy,
   output logic               done,
   output logic [15:0]        rdata,
   output logic               err_odd,
   output logic               err_abort,
   output logic               err_nxm,
   output logic               trap_req
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Counter value in the last cycle an ack is still accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             start;       // latch a new request this cycle
   logic             fail_odd;
   logic             fail_abort;
   logic             fail_nxm;
   logic             ack_ok;
   logic [CNT_W-1:0] cnt_q;
   logic [21:0]      addr_q;
   logic [15:0]      wdata_q;
   logic             we_q;
   logic [1:0]       be_q;
   logic             trap_pend;
   logic             lane_hi;     // byte access targets the high lane
   logic             byte_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      fail_odd   = 1'b0;
      fail_abort = 1'b0;
      fail_nxm   = 1'b0;
      ack_ok     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_rd || req_wr) begin
               // Odd word address is checked before the MMU abort.
               if (cpu_pa[0] && !req_byte) begin
                  fail_odd = 1'b1;
                  state_d  = DONE;
               end else if (mmu_abort) begin
                  fail_abort = 1'b1;
                  state_d    = DONE;
               end else begin
                  start   = 1'b1;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // An ack in the timeout cycle still wins.
            if (bus.mem_ack) begin
               ack_ok  = 1'b1;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               fail_nxm = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the latched request and result registers are reset as well, so
   // every output reads 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         trap_pend <= 1'b0;
         lane_hi   <= 1'b0;
         byte_q    <= 1'b0;
         rdata     <= '0;
         err_odd   <= 1'b0;
         err_abort <= 1'b0;
         err_nxm   <= 1'b0;
         trap_req  <= 1'b0;
      end else begin
         if (start) begin
            addr_q    <= {cpu_pa[21:1], 1'b0};
            we_q      <= req_wr;
            be_q      <= req_byte ? (cpu_pa[0] ? 2'b10 : 2'b01) : 2'b11;
            wdata_q   <= req_byte ? {2{cpu_wdata[7:0]}} : cpu_wdata;
            trap_pend <= mmu_trap;
            lane_hi   <= cpu_pa[0];
            byte_q    <= req_byte;
            cnt_q     <= '0;
         end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (ack_ok && !we_q) begin
            if (byte_q) rdata <= {8'h00, lane_hi ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0]};
            else        rdata <= bus.mem_rdata;
         end

         // Status is registered on the transition into DONE and dropped on
         // the following edge, so it is only ever high alongside done.
         err_odd   <= fail_odd;
         err_abort <= fail_abort;
         err_nxm   <= fail_nxm;
         trap_req  <= ack_ok & trap_pend;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign bus.mem_req   = (state_q == ACCESS);
   assign bus.mem_we    = bus.mem_req & we_q;
   assign bus.mem_be    = bus.mem_req ? be_q : 2'b00;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_cycle.sv
// tb_bus_cycle: self-checking bench for bus_cycle. A table of hand-computed
// transactions, a few multi-cycle sequences (request while busy, late ack,
// reset mid-access), then random transactions checked against a
// transaction-level reference model.
module tb_bus_cycle;
   localparam int   TIMEOUT = 16;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_rd, req_wr, req_byte;
   logic [21:0] cpu_pa;
   logic [15:0] cpu_wdata;
   logic        mmu_abort, mmu_trap;
   logic        busy, done;
   logic [15:0] rdata;
   logic        err_odd, err_abort, err_nxm, trap_req;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] model_rdata;

   bus_cycle_if bus ();

   bus_cycle #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_rd    (req_rd),
      .req_wr    (req_wr),
      .req_byte  (req_byte),
      .cpu_pa    (cpu_pa),
      .cpu_wdata (cpu_wdata),
      .mmu_abort (mmu_abort),
      .mmu_trap  (mmu_trap),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .err_odd   (err_odd),
      .err_abort (err_abort),
      .err_nxm   (err_nxm),
      .trap_req  (trap_req)
   );

   always #5 clk = ~clk;

   // One transaction: request inputs, ack timing, and expected results.
   // ack_cyc = cycle (after the request edge) in which mem_ack is driven,
   // 0 for none. e_done = cycle of the done pulse, e_req = mem_req cycles.
   typedef struct {
      logic        rd, wr, byte_acc;
      logic [21:0] pa;
      logic [15:0] wdata;
      logic        abort, trap;
      int          ack_cyc;
      logic [15:0] ack_data;
      int          e_done, e_req;
      logic [21:0] e_addr;
      logic [1:0]  e_be;
      logic        e_we;
      logic [15:0] e_wdata, e_rdata;
      logic        e_odd, e_abort, e_nxm, e_trap;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: outcome of one access from the access rules alone.
   function automatic vec_t model(input vec_t v, input logic [15:0] prev);
      vec_t e = v;
      logic hit;
      int   n;
      e.e_addr = '0; e.e_be = '0; e.e_we = 1'b0; e.e_wdata = '0;
      e.e_odd = 1'b0; e.e_abort = 1'b0; e.e_nxm = 1'b0; e.e_trap = 1'b0;
      e.e_rdata = prev;
      if (v.pa[0] && !v.byte_acc) begin
         e.e_done = 1; e.e_req = 0; e.e_odd = 1'b1;
      end else if (v.abort) begin
         e.e_done = 1; e.e_req = 0; e.e_abort = 1'b1;
      end else begin
         hit      = (v.ack_cyc >= 1 && v.ack_cyc <= TIMEOUT);
         n        = hit ? v.ack_cyc : TIMEOUT;
         e.e_req  = n;
         e.e_done = n + 1;
         e.e_addr = v.pa & ~22'h1;
         e.e_we   = v.wr;
         if (v.byte_acc) begin
            e.e_be    = v.pa[0] ? 2'b10 : 2'b01;
            e.e_wdata = {v.wdata[7:0], v.wdata[7:0]};
         end else begin
            e.e_be    = 2'b11;
            e.e_wdata = v.wdata;
         end
         e.e_nxm  = !hit;
         e.e_trap = hit & v.trap;
         if (hit && !v.wr)
            e.e_rdata = !v.byte_acc ? v.ack_data
                      : (v.pa[0] ? (v.ack_data >> 8) : (v.ack_data & 16'h00ff));
      end
      return e;
   endfunction

   // Issue v at the next edge, run until done (bounded), compare everything.
   // Called and returns at a falling edge.
   task automatic apply(input string tag, input vec_t v);
      logic [21:0] a0;
      logic [1:0]  be0;
      logic        we0;
      logic [15:0] wd0, rd;
      logic        stable, stray, f_odd, f_abort, f_nxm, f_trap;
      int          req_n, done_c;
      a0 = '0; be0 = '0; we0 = 1'b0; wd0 = '0; rd = '0;
      stable = 1'b1; stray = 1'b0;
      f_odd = 1'b0; f_abort = 1'b0; f_nxm = 1'b0; f_trap = 1'b0;
      req_n = 0; done_c = 0;
      req_rd = v.rd; req_wr = v.wr; req_byte = v.byte_acc; cpu_pa = v.pa;
      cpu_wdata = v.wdata; mmu_abort = v.abort; mmu_trap = v.trap;
      bus.mem_ack = 1'b0;
      for (int c = 1; c <= TIMEOUT + 8 && done_c == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            // Drop the request and scramble the request inputs: only the
            // values latched at the request edge may matter from here on.
            req_rd = 1'b0; req_wr = 1'b0; req_byte = ~v.byte_acc;
            cpu_pa = ~v.pa; cpu_wdata = ~v.wdata; mmu_abort = 1'b1; mmu_trap = ~v.trap;
         end
         if (bus.mem_req) begin
            if (req_n == 0) begin
               a0 = bus.mem_addr; be0 = bus.mem_be; we0 = bus.mem_we; wd0 = bus.mem_wdata;
            end else if (bus.mem_addr !== a0 || bus.mem_be !== be0 ||
                         bus.mem_we !== we0 || bus.mem_wdata !== wd0) begin
               stable = 1'b0;
            end
            req_n++;
         end
         if (done) begin
            done_c = c; rd = rdata;
            f_odd = err_odd; f_abort = err_abort; f_nxm = err_nxm; f_trap = trap_req;
         end else if (err_odd || err_abort || err_nxm || trap_req) begin
            stray = 1'b1;
         end
         bus.mem_ack   = (c == v.ack_cyc);
         bus.mem_rdata = (c == v.ack_cyc) ? v.ack_data : 16'($urandom);
      end
      bus.mem_ack = 1'b0;
      mmu_abort = 1'b0;
      check({tag, ".done_cycle"}, 32'(done_c), 32'(v.e_done));
      check({tag, ".req_cycles"}, 32'(req_n), 32'(v.e_req));
      if (v.e_req > 0) begin
         check({tag, ".mem_addr"},  32'(a0),     32'(v.e_addr));
         check({tag, ".mem_be"},    32'(be0),    32'(v.e_be));
         check({tag, ".mem_we"},    32'(we0),    32'(v.e_we));
         check({tag, ".mem_wdata"}, 32'(wd0),    32'(v.e_wdata));
         check({tag, ".stable"},    32'(stable), 32'(1));
      end
      check({tag, ".rdata"},     32'(rd),      32'(v.e_rdata));
      check({tag, ".err_odd"},   32'(f_odd),   32'(v.e_odd));
      check({tag, ".err_abort"}, 32'(f_abort), 32'(v.e_abort));
      check({tag, ".err_nxm"},   32'(f_nxm),   32'(v.e_nxm));
      check({tag, ".trap_req"},  32'(f_trap),  32'(v.e_trap));
      check({tag, ".flags_outside_done"}, 32'(stray), 32'(0));
      @(negedge clk);
      check({tag, ".done_one_cycle"}, 32'({done, busy}), 32'(0));
   endtask

   // Free-form sequence: bit c of each mask is driven during cycle c
   // (bit 0 = before the request edge). Counts mem_req and done cycles.
   task automatic seq(input int n, input logic [63:0] rd_m, input logic [63:0] ack_m,
                      input logic [63:0] rst_m, input logic [15:0] data,
                      output int req_n, output int done_n, output int done_c,
                      output logic [15:0] rd_done);
      req_n = 0; done_n = 0; done_c = 0; rd_done = '0;
      for (int c = 0; c <= n; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (bus.mem_req) req_n++;
            if (done) begin
               done_n++;
               if (done_c == 0) begin
                  done_c  = c;
                  rd_done = rdata;
               end
            end
         end
         req_rd = rd_m[c]; bus.mem_ack = ack_m[c]; reset = rst_m[c];
         bus.mem_rdata = data;
      end
      req_rd = 1'b0; bus.mem_ack = 1'b0; reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          req_n, done_n, done_c;
      logic [15:0] rd_done;
      vec_t        v;

      //            rd wr by pa             wdata       ab tr ack data          done req addr          be    we wdata       rdata         odd abt nxm trp
      tbl[0]  = '{T, F, F, 22'o0001000, 16'h0000,   F, F, 3,  16'o123456,   4,  3,  22'o0001000, 2'b11, F, 16'h0000,   16'o123456, F, F, F, F};
      tbl[1]  = '{F, T, T, 22'o0001001, 16'o000252, F, F, 2,  16'h0000,     3,  2,  22'o0001000, 2'b10, T, 16'o125252, 16'o123456, F, F, F, F};
      tbl[2]  = '{T, F, T, 22'o0001001, 16'h0000,   F, F, 1,  16'o177400,   2,  1,  22'o0001000, 2'b10, F, 16'h0000,   16'o000377, F, F, F, F};
      tbl[3]  = '{T, F, T, 22'o0001000, 16'h0000,   F, F, 1,  16'o177400,   2,  1,  22'o0001000, 2'b01, F, 16'h0000,   16'h0000,   F, F, F, F};
      tbl[4]  = '{T, F, F, 22'o0001003, 16'h0000,   F, F, 1,  16'hffff,     1,  0,  22'h0,       2'b00, F, 16'h0000,   16'h0000,   T, F, F, F};
      tbl[5]  = '{T, F, F, 22'o0001003, 16'h0000,   T, F, 1,  16'hffff,     1,  0,  22'h0,       2'b00, F, 16'h0000,   16'h0000,   T, F, F, F};
      tbl[6]  = '{T, F, F, 22'o0002000, 16'h0000,   F, F, 0,  16'hffff,     17, 16, 22'o0002000, 2'b11, F, 16'h0000,   16'h0000,   F, F, T, F};
      tbl[7]  = '{T, F, F, 22'o0002000, 16'h0000,   F, F, 16, 16'hbeef,     17, 16, 22'o0002000, 2'b11, F, 16'h0000,   16'hbeef,   F, F, F, F};
      tbl[8]  = '{T, F, F, 22'o0004000, 16'h0000,   F, T, 1,  16'h1234,     2,  1,  22'o0004000, 2'b11, F, 16'h0000,   16'h1234,   F, F, F, T};
      tbl[9]  = '{T, F, F, 22'o0004000, 16'h0000,   T, T, 1,  16'hffff,     1,  0,  22'h0,       2'b00, F, 16'h0000,   16'h1234,   F, T, F, F};
      tbl[10] = '{F, T, F, 22'o0007776, 16'ha5c3,   F, F, 5,  16'hffff,     6,  5,  22'o0007776, 2'b11, T, 16'ha5c3,   16'h1234,   F, F, F, F};
      tbl[11] = '{T, F, F, 22'o0006000, 16'h0000,   F, T, 0,  16'hffff,     17, 16, 22'o0006000, 2'b11, F, 16'h0000,   16'h1234,   F, F, T, F};
      tbl[12] = '{F, T, T, 22'h3ffffe,  16'h12ab,   F, F, 1,  16'hffff,     2,  1,  22'h3ffffe,  2'b01, T, 16'habab,   16'h1234,   F, F, F, F};
      tbl[13] = '{T, T, F, 22'o0000100, 16'h1111,   F, F, 1,  16'hffff,     2,  1,  22'o0000100, 2'b11, T, 16'h1111,   16'h1234,   F, F, F, F};
      tbl[14] = '{T, F, T, 22'h3fffff,  16'h0000,   F, F, 2,  16'hc3a5,     3,  2,  22'h3ffffe,  2'b10, F, 16'h0000,   16'h00c3,   F, F, F, F};

      reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_byte = 1'b0;
      cpu_pa = '0; cpu_wdata = '0; mmu_abort = 1'b0; mmu_trap = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 16'hffff;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state.
      check("reset.busy_done", 32'({busy, done}), 32'(0));
      check("reset.mem_req_we_be", 32'({bus.mem_req, bus.mem_we, bus.mem_be}), 32'(0));
      check("reset.mem_addr", 32'(bus.mem_addr), 32'(0));
      check("reset.mem_wdata", 32'(bus.mem_wdata), 32'(0));
      check("reset.rdata", 32'(rdata), 32'(0));
      check("reset.flags", 32'({err_odd, err_abort, err_nxm, trap_req}), 32'(0));

      for (int i = 0; i < 15; i++) apply($sformatf("row%0d", i), tbl[i]);

      // Request held/re-issued while busy: exactly one access and one done.
      req_wr = 1'b0; req_byte = 1'b0; cpu_pa = 22'o0001000; mmu_abort = 1'b0; mmu_trap = 1'b0;
      seq(10, 64'b111101, 64'b10000, 64'b0, 16'h0bb0, req_n, done_n, done_c, rd_done);
      check("busy_req.req_cycles", 32'(req_n), 32'(4));
      check("busy_req.done_count", 32'(done_n), 32'(1));
      check("busy_req.done_cycle", 32'(done_c), 32'(5));
      check("busy_req.rdata", 32'(rd_done), 32'(16'h0bb0));

      // Ack repeated into DONE and IDLE: ignored.
      seq(8, 64'b1, 64'b11100, 64'b0, 16'h5a5a, req_n, done_n, done_c, rd_done);
      check("late_ack.req_cycles", 32'(req_n), 32'(2));
      check("late_ack.done_count", 32'(done_n), 32'(1));
      check("late_ack.done_cycle", 32'(done_c), 32'(3));
      check("late_ack.rdata", 32'(rd_done), 32'(16'h5a5a));
      check("late_ack.idle", 32'({busy, bus.mem_req}), 32'(0));

      // Reset during cycle 5 of an unanswered access.
      seq(7, 64'b1, 64'b0, 64'b100000, 16'h0000, req_n, done_n, done_c, rd_done);
      check("reset_mid.req_cycles", 32'(req_n), 32'(5));
      check("reset_mid.done_count", 32'(done_n), 32'(0));
      check("reset_mid.idle", 32'({busy, bus.mem_req}), 32'(0));
      check("reset_mid.rdata", 32'(rdata), 32'(0));
      model_rdata = 16'h0000;
      v = '{T, F, F, 22'o0003000, 16'h0000, F, F, 2, 16'h7e57,
            0, 0, 22'h0, 2'b00, F, 16'h0000, 16'h0000, F, F, F, F};
      v = model(v, model_rdata);
      apply("after_reset", v);
      model_rdata = v.e_rdata;

      // Random transactions against the reference model.
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind       = $urandom_range(0, 3);
         v.rd       = (kind != 2);
         v.wr       = (kind >= 2);
         v.byte_acc = 1'($urandom_range(0, 1));
         v.pa       = 22'($urandom);
         v.wdata    = 16'($urandom);
         v.abort    = ($urandom_range(0, 7) == 0);
         v.trap     = 1'($urandom_range(0, 1));
         v.ack_cyc  = $urandom_range(0, 18);
         v.ack_data = 16'($urandom);
         v = model(v, model_rdata);
         apply($sformatf("rand%0d", i), v);
         model_rdata = v.e_rdata;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
